// File: rtl/neuron_cluster_pkg.sv
// Shared definitions for the LIF neuron cluster: FSM states, config selectors
// and a saturating adder used by both the accumulate and the update paths.
// Pure declarations; no clocked logic lives here.
package neuron_cluster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  localparam logic [1:0] CFG_WEIGHT = 2'd0;
  localparam logic [1:0] CFG_VTH    = 2'd1;
  localparam logic [1:0] CFG_VRESET = 2'd2;
  localparam logic [1:0] CFG_MISC   = 2'd3;

  // Add two sign-extended operands and clamp to the signed range of a pw-bit
  // word. Operands must already lie inside that range, so the 64-bit sum
  // itself never overflows (valid for pw <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int pw);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (pw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (pw - 1));
    if (sum > hi) begin
      sat_add = hi;
    end else if (sum < lo) begin
      sat_add = lo;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/neuron_cluster_update_unit.sv
// One neuron's end-of-step update: leak, integrate, threshold and refractory.
// Purely combinational; the cluster FSM feeds it one neuron per cycle.
// No handshake: results are consumed in the same cycle they are produced.
module neuron_update_unit
  import neuron_cluster_pkg::*;
#(
  parameter int PW = 32,
  parameter int RW = 4
) (
  input  logic [PW-1:0] v,
  input  logic [PW-1:0] acc,
  input  logic [RW-1:0] refrac_cnt,
  input  logic [4:0]    decay_shift,
  input  logic [PW-1:0] v_th,
  input  logic [PW-1:0] v_reset,
  input  logic [RW-1:0] refrac,
  output logic [PW-1:0] v_next,
  output logic [RW-1:0] refrac_next,
  output logic          fire
);

  logic signed [PW-1:0] leak;
  logic signed [PW-1:0] v_decayed;
  logic signed [PW-1:0] v_sum;

  // Leak by a power of two (shift 0 means no leak at all), add the step's
  // accumulated input with saturation, then decide fire / hold / integrate.
  always_comb begin
    leak = '0;
    if (decay_shift != '0) begin
      leak = $signed(v) >>> decay_shift;
    end
    // v - (v >>> s) always stays between v and 0, so this cannot overflow.
    v_decayed   = $signed(v) - leak;
    v_sum       = PW'(sat_add(64'(v_decayed), 64'($signed(acc)), PW));
    v_next      = v;
    refrac_next = refrac_cnt;
    fire        = 1'b0;
    if (refrac_cnt != '0) begin
      refrac_next = refrac_cnt - 1'b1;
    end else if (v_sum >= $signed(v_th)) begin
      fire        = 1'b1;
      v_next      = v_reset;
      refrac_next = refrac;
    end else begin
      v_next = v_sum;
    end
  end

endmodule

// File: rtl/neuron_cluster.sv
// Cluster of N_NEURONS LIF neurons sharing one time-multiplexed datapath.
// Event: N_NEURONS cycles of accumulate; time step: spike vector N_NEURONS+1 cycles later.
// in_ready is low whenever the sweep FSM is not idle; config writes outside IDLE are dropped.
module neuron_cluster
  import neuron_cluster_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int N_INPUTS  = 16,
  parameter int WW        = 16,
  parameter int PW        = 32,
  parameter int RW        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cfg_we,
  input  logic [1:0]                              cfg_sel,
  input  logic [$clog2(N_NEURONS*N_INPUTS)-1:0]   cfg_addr,
  input  logic [PW-1:0]                           cfg_data,
  input  logic                                    in_valid,
  input  logic [$clog2(N_INPUTS)-1:0]             in_addr,
  output logic                                    in_ready,
  input  logic                                    time_step,
  output logic                                    busy,
  output logic                                    spike_valid,
  output logic [N_NEURONS-1:0]                    spike_vec
);

  localparam int NB = $clog2(N_NEURONS);
  localparam int IB = $clog2(N_INPUTS);
  localparam logic [PW-1:0] VTH_MAX = {1'b0, {(PW-1){1'b1}}};

  state_t state;
  state_t state_nx;

  logic [NB-1:0] n;
  logic [IB-1:0] ev_addr;
  logic          ts_pending;
  logic          last;

  logic [PW-1:0] v          [N_NEURONS];
  logic [PW-1:0] acc        [N_NEURONS];
  logic [RW-1:0] rcnt       [N_NEURONS];
  logic [WW-1:0] weight     [N_NEURONS*N_INPUTS];

  logic [PW-1:0] v_th;
  logic [PW-1:0] v_reset;
  logic [RW-1:0] refrac;
  logic [4:0]    decay_shift;

  logic [N_NEURONS-1:0] spike_work;

  logic [WW-1:0] w_rd;
  logic [PW-1:0] acc_sum;
  logic [PW-1:0] v_next;
  logic [RW-1:0] refrac_next;
  logic          fire;

  assign last    = (n == NB'(N_NEURONS - 1));
  assign w_rd    = weight[{n, ev_addr}];
  assign acc_sum = PW'(sat_add(64'($signed(acc[n])), 64'($signed(w_rd)), PW));

  neuron_update_unit #(
    .PW (PW),
    .RW (RW)
  ) u_update (
    .v           (v[n]),
    .acc         (acc[n]),
    .refrac_cnt  (rcnt[n]),
    .decay_shift (decay_shift),
    .v_th        (v_th),
    .v_reset     (v_reset),
    .refrac      (refrac),
    .v_next      (v_next),
    .refrac_next (refrac_next),
    .fire        (fire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs. An event wins over a same-cycle time
  // step; the step is remembered in ts_pending and runs after the accumulate.
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    spike_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nx = ST_ACCUM;
        end else if (time_step) begin
          state_nx = ST_UPDATE;
        end
      end
      ST_ACCUM: begin
        if (last) begin
          state_nx = (ts_pending || time_step) ? ST_UPDATE : ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (last) begin
          state_nx = ST_EMIT;
        end
      end
      ST_EMIT: begin
        spike_valid = 1'b1;
        state_nx    = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Per-neuron state, config registers and the sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      n           <= '0;
      ev_addr     <= '0;
      ts_pending  <= 1'b0;
      v_th        <= VTH_MAX;
      v_reset     <= '0;
      refrac      <= '0;
      decay_shift <= '0;
      spike_work  <= '0;
      spike_vec   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i]    <= '0;
        acc[i]  <= '0;
        rcnt[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          n <= '0;
          if (in_valid) begin
            ev_addr    <= in_addr;
            ts_pending <= time_step;
          end
          if (cfg_we) begin
            case (cfg_sel)
              CFG_VTH:    v_th <= cfg_data;
              CFG_VRESET: v_reset <= cfg_data;
              CFG_MISC:   {refrac, decay_shift} <= cfg_data[RW+4:0];
              default:    ;
            endcase
          end
        end
        ST_ACCUM: begin
          // Refractory neurons ignore incoming spikes entirely.
          if (rcnt[n] == '0) begin
            acc[n] <= acc_sum;
          end
          n <= n + 1'b1;
          // The pending step is consumed by the transition at the last neuron.
          ts_pending <= last ? 1'b0 : (ts_pending | time_step);
        end
        ST_UPDATE: begin
          v[n]          <= v_next;
          acc[n]        <= '0;
          rcnt[n]       <= refrac_next;
          spike_work[n] <= fire;
          ts_pending    <= 1'b0;
          n             <= n + 1'b1;
          // Lower bits were all rewritten earlier in this sweep; the top bit
          // is being produced right now, so splice it in directly.
          if (last) begin
            spike_vec <= {fire, spike_work[N_NEURONS-2:0]};
          end
        end
        default: ;
      endcase
    end
  end

  // Weight RAM: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_IDLE && cfg_we && cfg_sel == CFG_WEIGHT) begin
      weight[cfg_addr] <= cfg_data[WW-1:0];
    end
  end

endmodule

// File: tb/tb_neuron_cluster.sv
// Self-checking bench for neuron_cluster: timeline-based reference model plus
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_neuron_cluster;

  localparam int N  = 8;
  localparam int NI = 16;
  localparam int WW = 16;
  localparam int PW = 32;
  localparam int RW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [6:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        in_valid;
  logic [3:0]  in_addr;
  logic        in_ready;
  logic        time_step;
  logic        busy;
  logic        spike_valid;
  logic [7:0]  spike_vec;

  always #5 clk = ~clk;

  neuron_cluster #(.N_NEURONS(N), .N_INPUTS(NI), .WW(WW), .PW(PW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_valid(in_valid), .in_addr(in_addr), .in_ready(in_ready),
    .time_step(time_step), .busy(busy), .spike_valid(spike_valid), .spike_vec(spike_vec)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: neuron state as plain integers plus a timeline of when
  // the cluster is free again and when the next spike vector appears.
  longint mv[N];
  longint macc[N];
  int     mrc[N];
  longint mw[N*NI];
  longint vth, vreset;
  int     mrefrac, mds;
  longint cyc, free_at, emit_at, accum_end;
  bit     pend;
  logic [7:0] last_vec, next_vec;

  int     sv_count = 0;
  longint last_sv_cyc = -1;
  bit     rdy_seen, sv_now;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint s32(input logic [31:0] d);
    return longint'($signed(d));
  endfunction

  function automatic longint s16(input logic [15:0] d);
    return longint'($signed(d));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; macc[i] = 0; mrc[i] = 0;
    end
    vth = 64'sd2147483647; vreset = 0; mrefrac = 0; mds = 0;
  endtask

  // Apply one whole time step to every neuron at once.
  task automatic sweep();
    longint leak, vp;
    next_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (mrc[i] != 0) begin
        mrc[i]--;
      end else begin
        leak = (mds == 0) ? 0 : (mv[i] >>> mds);
        vp = sat(mv[i] - leak + macc[i]);
        if (vp >= vth) begin
          next_vec[i] = 1'b1; mv[i] = vreset; mrc[i] = mrefrac;
        end else begin
          mv[i] = vp;
        end
      end
      macc[i] = 0;
    end
    emit_at = cyc + N + 1;
    free_at = cyc + N + 2;
  endtask

  // One clock cycle: compare outputs against the model, drive inputs, advance the model.
  task automatic step(input bit iv, input int ia, input bit ts, input bit we, input int sel,
                      input int addr, input logic [31:0] data, input bit r);
    @(negedge clk);
    if (cyc == emit_at) last_vec = next_vec;
    check("in_ready", in_ready, (cyc >= free_at) ? 1 : 0);
    check("busy", busy, (cyc >= free_at) ? 0 : 1);
    check("spike_valid", spike_valid, (cyc == emit_at) ? 1 : 0);
    check("spike_vec", spike_vec, last_vec);
    if (cyc == emit_at) begin
      for (int i = 0; i < N; i++) check($sformatf("v[%0d]", i), s32(dut.v[i]), mv[i]);
    end
    rdy_seen = in_ready;
    sv_now = spike_valid;
    if (spike_valid) begin
      sv_count++;
      last_sv_cyc = cyc;
    end
    rst = r; in_valid = iv; in_addr = ia[3:0]; time_step = ts;
    cfg_we = we; cfg_sel = sel[1:0]; cfg_addr = addr[6:0]; cfg_data = data;
    if (r) begin
      model_reset();
      last_vec = '0; free_at = cyc + 1; emit_at = -1; accum_end = -1; pend = 0;
    end else if (cyc >= free_at) begin
      if (we) begin
        case (sel)
          0: mw[addr] = s16(data[15:0]);
          1: vth = s32(data);
          2: vreset = s32(data);
          default: begin mrefrac = int'(data[8:5]); mds = int'(data[4:0]); end
        endcase
      end
      if (iv) begin
        for (int i = 0; i < N; i++)
          if (mrc[i] == 0) macc[i] = sat(macc[i] + mw[i*NI + ia]);
        accum_end = cyc + N; free_at = cyc + N + 1; pend = ts;
      end else if (ts) begin
        sweep();
      end
    end else if (cyc <= accum_end) begin
      if (ts) pend = 1;
      if (cyc == accum_end && pend) begin
        sweep();
        pend = 0;
      end
    end
    cyc++;
  endtask

  task automatic idle();                         step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tick();                         step(0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic ev(input int a, input bit ts);  step(1, a, ts, 0, 0, 0, 0, 0); endtask
  task automatic cfg(input int sel, input int addr, input logic [31:0] d);
    step(0, 0, 0, 1, sel, addr, d, 0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      idle();
      if (rdy_seen) break;
    end
    check("wait_idle", rdy_seen, 1);
  endtask

  task automatic wait_spike();
    for (int k = 0; k < 40; k++) begin
      idle();
      if (sv_now) break;
    end
    check("wait_spike", sv_now, 1);
  endtask

  initial begin
    longint ts_c;
    int nlow, base;
    bit exp_fire [5];
    rst = 1'b1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
    in_valid = 0; in_addr = 0; time_step = 0;
    model_reset();
    cyc = 0; free_at = 0; emit_at = -1; accum_end = -1; pend = 0;
    last_vec = '0; next_vec = '0;
    for (int i = 0; i < N*NI; i++) mw[i] = 0;
    repeat (3) @(posedge clk);

    // Reset state, pinned by literals.
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_vec", spike_vec, 0);
    for (int i = 0; i < N; i++) check($sformatf("rst_v[%0d]", i), s32(dut.v[i]), 0);

    for (int a = 0; a < N*NI; a++) cfg(0, a, 32'd0);

    // Accumulate and fire.
    cfg(1, 0, 32'd100);
    for (int i = 0; i < N; i++) cfg(0, i*NI + 3, 32'd60);
    ev(3, 0);
    nlow = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (rdy_seen) break;
      nlow++;
    end
    check("accum_ready_low", nlow, 8);
    ev(3, 0);
    wait_idle();
    ts_c = cyc;
    tick();
    wait_spike();
    check("ts_latency", last_sv_cyc - ts_c, 9);
    check("fire_all", spike_vec, 8'hFF);
    check("fire_v0_reset", s32(dut.v[0]), 0);

    // Decay by halving.
    cfg(3, 0, 32'd1);
    cfg(1, 0, 32'd1000);
    cfg(0, 0, 32'd80);
    ev(0, 1);
    wait_spike();
    check("decay_v0_80", s32(dut.v[0]), 80);
    check("decay_vec_a", spike_vec, 0);
    wait_idle(); tick(); wait_spike();
    check("decay_v0_40", s32(dut.v[0]), 40);
    wait_idle(); tick(); wait_spike();
    check("decay_v0_20", s32(dut.v[0]), 20);
    check("decay_vec_c", spike_vec, 0);

    // Refractory period of two steps (no decay): 20+80 fires, then two muted steps.
    cfg(3, 0, 32'd64);
    cfg(1, 0, 32'd100);
    exp_fire[0] = 1; exp_fire[1] = 0; exp_fire[2] = 0; exp_fire[3] = 0; exp_fire[4] = 1;
    for (int s = 0; s < 5; s++) begin
      wait_idle();
      ev(0, 1);
      wait_spike();
      check($sformatf("refrac_step%0d", s), spike_vec, {7'd0, exp_fire[s]});
    end

    // Saturation at the positive and negative limits.
    wait_idle();
    cfg(3, 0, 32'd0);
    tick(); wait_spike(); wait_idle();
    tick(); wait_spike(); wait_idle();
    cfg(2, 0, 32'h7FFF0000);
    cfg(1, 0, 32'd0);
    tick(); wait_spike();
    check("load_high", spike_vec, 8'hFF);
    wait_idle();
    cfg(1, 0, 32'h7FFFFFFF);
    for (int i = 0; i < N; i++) cfg(0, i*NI + 5, 32'h7FFF);
    for (int e = 0; e < 3; e++) begin ev(5, 0); wait_idle(); end
    tick(); wait_spike();
    check("sat_pos_fire", spike_vec, 8'hFF);
    wait_idle();
    cfg(2, 0, 32'h80010000);
    cfg(1, 0, 32'h80000000);
    tick(); wait_spike();
    check("load_low", spike_vec, 8'hFF);
    wait_idle();
    cfg(1, 0, 32'd0);
    for (int i = 0; i < N; i++) cfg(0, i*NI + 6, 32'h8000);
    for (int e = 0; e < 3; e++) begin ev(6, 0); wait_idle(); end
    tick(); wait_spike();
    check("sat_neg_nofire", spike_vec, 0);
    check("sat_neg_v0", s32(dut.v[0]), -64'sd2147483648);

    // Collisions.
    wait_idle();
    cfg(2, 0, 32'd0);
    cfg(1, 0, 32'd100);
    base = sv_count;
    ev(3, 1); idle(); tick();
    for (int k = 0; k < 30; k++) idle();
    check("merged_steps_one_sweep", sv_count - base, 1);
    base = sv_count;
    tick(); idle(); idle(); tick();
    for (int k = 0; k < 30; k++) idle();
    check("step_in_update_dropped", sv_count - base, 1);
    base = sv_count;
    ev(3, 1); idle(); idle();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) idle();
    check("rst_mid_accum_no_spike", sv_count - base, 0);
    check("rst_mid_accum_acc0", s32(dut.acc[0]), 0);
    check("rst_mid_accum_ready", rdy_seen, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit r, iv, ts, we;
      int sel, addr;
      logic [31:0] d;
      r    = ($urandom_range(0, 999) == 0);
      iv   = ($urandom_range(0, 99) < 30);
      ts   = ($urandom_range(0, 99) < 10);
      we   = ($urandom_range(0, 99) < 8);
      sel  = int'($urandom_range(0, 3));
      addr = int'($urandom_range(0, N*NI - 1));
      case (sel)
        0: d = 32'(int'($urandom_range(0, 600)) - 200);
        1: d = 32'($urandom_range(0, 1500));
        2: d = 32'(int'($urandom_range(0, 200)) - 100);
        default: d = {23'd0, 4'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      endcase
      step(iv, int'($urandom_range(0, NI - 1)), ts, we, sel, addr, d, r);
    end
    for (int k = 0; k < 30; k++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
